// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit queue.
package uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int UART_TXQ_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } txq_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x W register array: synchronous write, combinational read by address.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEPTH_DEFAULT,
    parameter int W     = UART_DATA_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding a uart_tx with a start/done handshake and one-cycle inter-byte gap.
// Optional saturating overflow counter enabled by defining UART_TXQ_OVF_CNT_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_en_i,
    input  logic [UART_DATA_W-1:0]   wr_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     tx_start_o,
    output logic [UART_DATA_W-1:0]   tx_data_o,
    input  logic                     tx_done_i,
    output logic                     overflow_o,
    output logic [7:0]               ovf_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    txq_state_e             state_q;
    logic                   tx_start_q;
    logic [UART_DATA_W-1:0] tx_data_q;
    logic                   done_q;
    logic                   overflow_q;
    logic [UART_DATA_W-1:0] rd_data;
    logic                   full, empty;
    logic                   pop, push, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // The FSM is the only consumer; a pop frees a slot in the same cycle.
    assign pop  = (state_q == IDLE) && !empty;
    assign push = wr_en_i && (!full || pop);
    assign drop = wr_en_i && full && !pop;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= drop;
        end
    end

    // done_q resets high so a tx_done_i level already high never counts as an edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b1;
        end else begin
            done_q <= tx_done_i;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        tx_data_q  <= rd_data;
                        tx_start_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_done_i && !done_q) begin
                        tx_start_q <= 1'b0;
                        state_q    <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_q <= 8'h00;
        end else if (overflow_q && (ovf_cnt_q != 8'hFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
`else
    assign ovf_cnt_o = 8'h00;
`endif

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue-level reference model, directed scenarios, random traffic.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
`ifdef UART_TXQ_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_done;
    logic       full_o, empty_o, tx_start_o, overflow_o;
    logic [4:0] count_o;
    logic [7:0] tx_data_o, ovf_cnt_o;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_data_i  (wr_data),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .tx_done_i  (tx_done),
        .overflow_o (overflow_o),
        .ovf_cnt_o  (ovf_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
        end
    endtask

    // Reference model: accepted bytes wait in exp_q until the transmitter takes them.
    byte unsigned exp_q[$];
    int  m_cnt  = 0;
    bit  m_busy = 0;
    bit  m_gap  = 0;
    bit  m_dq   = 1;
    bit  m_ovf  = 0;
    int  m_ovfc = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_busy = 0; m_gap = 0; m_dq = 1; m_ovf = 0; m_ovfc = 0;
                exp_q.delete();
            end else begin
                bit take;
                take = !m_busy && !m_gap && (m_cnt > 0);
                if (m_ovf && m_ovfc < 255) m_ovfc++;
                m_ovf = 0;
                if (wr_en) begin
                    if (m_cnt < DEPTH || take) begin
                        exp_q.push_back(wr_data);
                        m_cnt++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (take) begin
                    m_cnt--;
                    m_busy = 1;
                end else if (m_busy && tx_done && !m_dq) begin
                    m_busy = 0;
                    m_gap  = 1;
                end else if (m_gap) begin
                    m_gap = 0;
                end
                m_dq = tx_done;
            end
        end
    end

    // Monitor: compares outputs each cycle and pops the scoreboard on each new start.
    bit   mon_en = 0;
    bit   prev_start = 0;
    logic [7:0] cur = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("count", count_o, m_cnt);
                check("full", full_o, (m_cnt == DEPTH) ? 1 : 0);
                check("empty", empty_o, (m_cnt == 0) ? 1 : 0);
                check("tx_start", tx_start_o, m_busy);
                check("overflow", overflow_o, m_ovf);
                check("ovf_cnt", ovf_cnt_o, OVF_EN ? m_ovfc : 0);
                if (tx_start_o && !prev_start) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL tx_byte at %0t: got start with data 0x%0h, expected no transfer", $time, tx_data_o);
                    end else begin
                        cur = exp_q.pop_front();
                        check("tx_byte", tx_data_o, cur);
                    end
                end else if (tx_start_o) begin
                    check("tx_hold", tx_data_o, cur);
                end
            end
            prev_start = tx_start_o;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        wr_en = 1'b0;
        tx_done = 1'b0;
        while ((m_cnt > 0 || m_busy || m_gap) && n < 200) begin
            pulse_done();
            idle(1);
            n++;
        end
        check("drain_done", (m_cnt > 0 || m_busy || m_gap) ? 1 : 0, 0);
    endtask

    initial begin
        int dens;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
        idle(3);
        rst = 1'b0;
        mon_en = 1;
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_start", tx_start_o, 0);
        check("rst_data", tx_data_o, 8'h00);
        check("rst_ovf", overflow_o, 0);
        check("rst_ovfcnt", ovf_cnt_o, 0);
        idle(2);

        // Single byte
        push(8'hA5);
        idle(1);
        check("single_start", tx_start_o, 1);
        check("single_data", tx_data_o, 8'hA5);
        check("single_count", count_o, 0);
        pulse_done();
        check("single_stop", tx_start_o, 0);
        idle(3);

        // Burst 01..10 with done held low
        for (int i = 1; i <= 16; i++) push(8'(i));
        check("burst_count", count_o, 15);
        check("burst_start", tx_start_o, 1);
        drain();
        idle(2);

        // Overflow, then push-while-full with a pop in the same cycle
        for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
        check("ovf_full", full_o, 1);
        push(8'hFF);
        check("ovf_pulse", overflow_o, 1);
        idle(1);
        check("ovf_pulse_end", overflow_o, 0);
        check("ovf_cnt_val", ovf_cnt_o, OVF_EN ? 1 : 0);
        pulse_done();
        idle(1);
        push(8'h77);
        check("fullpop_count", count_o, 16);
        check("fullpop_ovf", overflow_o, 0);
        drain();
        idle(2);

        // Reset while sending with 5 bytes queued
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        check("mid_count", count_o, 5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rstmid_count", count_o, 0);
        check("rstmid_start", tx_start_o, 0);
        check("rstmid_empty", empty_o, 1);
        push(8'h3C);
        idle(1);
        check("after_rst_data", tx_data_o, 8'h3C);
        pulse_done();
        idle(3);

        // Stuck done through reset release
        tx_done = 1'b1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        push(8'h5A);
        idle(6);
        check("stuck_hold", tx_start_o, 1);
        tx_done = 1'b0;
        idle(1);
        check("stuck_still", tx_start_o, 1);
        tx_done = 1'b1;
        idle(1);
        check("stuck_release", tx_start_o, 0);
        tx_done = 1'b0;
        idle(3);

        // Random traffic
        dens = 40;
        for (int c = 0; c < 2500; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0: dens = 10;
                    1: dens = 40;
                    default: dens = 90;
                endcase
            end
            wr_en   = ($urandom_range(0, 99) < dens);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 2) == 0) tx_done = ~tx_done;
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        drain();
        idle(3);
        check("leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
